// File: rtl/paddle_ctrl_pkg.sv
// Shared definitions for the paddle controller: encoder direction codes and
// Gray-sequence helpers used by the quadrature decoder.
package paddle_ctrl_pkg;

    // DIR_INC is the forward Gray count 00->01->11->10, which moves the paddle toward bit 0.
    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_INC  = 2'b01,
        DIR_DEC  = 2'b10
    } dir_t;

    function automatic logic [1:0] gray_next(input logic [1:0] g);
        case (g)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] gray_prev(input logic [1:0] g);
        case (g)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/paddle_ctrl_quad_decoder.sv
// Rotary encoder front end: synchroniser, previous-sample register and
// single-step Gray decode with two-phase jump detection.
module quad_decoder
    import paddle_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] encoder_value,
    output logic [1:0] dir,
    output logic       illegal
);

    logic [1:0] sync_q [SYNC_STAGES];
    logic [1:0] prev_q;
    logic [1:0] sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= encoder_value;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_out;
        end
    end

    // Both phases changing at once cannot be ordered, so it is flagged rather than decoded.
    always_comb begin
        dir     = DIR_NONE;
        illegal = 1'b0;
        if (sync_out == prev_q) begin
            dir = DIR_NONE;
        end else if (sync_out == gray_next(prev_q)) begin
            dir = DIR_INC;
        end else if (sync_out == gray_prev(prev_q)) begin
            dir = DIR_DEC;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position/length tracker driven by a quadrature encoder, with optional
// same-direction acceleration and clamp or wrap-around field edges.
module paddle_ctrl
    import paddle_ctrl_pkg::*;
#(
    parameter int unsigned FIELD_W      = 16,
    parameter int unsigned LEN_W        = 4,
    parameter int unsigned RESET_LEN    = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned ACCEL_WINDOW = 1024,
    parameter int unsigned ACCEL_MAX    = 4,
    parameter int unsigned WRAP         = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [LEN_W-1:0]           len_i,
    input  logic                       accel_en,
    input  logic [1:0]                 encoder_value,
    output logic [FIELD_W-1:0]         paddle_o,
    output logic [$clog2(FIELD_W)-1:0] pos_o,
    output logic                       at_edge_lo,
    output logic                       at_edge_hi,
    output logic                       illegal_o
);

    localparam int unsigned POS_W  = $clog2(FIELD_W);
    localparam int unsigned LENQ_W = $clog2(FIELD_W + 1);
    localparam int unsigned GAP_W  = $clog2(ACCEL_WINDOW + 1);
    localparam int unsigned STEP_W = $clog2(ACCEL_MAX + 1);

    logic [1:0]        dir_raw;
    dir_t              dir;
    logic              illegal;

    logic [POS_W-1:0]  pos_q;
    logic [LENQ_W-1:0] len_q;
    logic [GAP_W-1:0]  gap_q;
    logic [STEP_W-1:0] step_q;
    dir_t              last_dir_q;

    int unsigned       len_next;
    int unsigned       lim;
    int unsigned       step_size;
    int unsigned       pos_cur;
    int unsigned       pos_new;
    logic              streak;

    quad_decoder #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dec (
        .clk           (clk),
        .reset_n       (reset_n),
        .encoder_value (encoder_value),
        .dir           (dir_raw),
        .illegal       (illegal)
    );

    assign dir = dir_t'(dir_raw);

    always_comb begin
        len_next = 32'(len_i);
        if (len_next == 0) begin
            len_next = 1;
        end else if (len_next > FIELD_W) begin
            len_next = FIELD_W;
        end
        lim = FIELD_W - len_next;

        streak    = accel_en && (dir == last_dir_q) && (32'(gap_q) < ACCEL_WINDOW);
        step_size = 1;
        if (streak) begin
            step_size = (32'(step_q) + 1 > ACCEL_MAX) ? ACCEL_MAX : 32'(step_q) + 1;
        end

        pos_cur = 32'(pos_q);
        pos_new = pos_cur;
        if (dir == DIR_INC) begin
            if (pos_cur >= step_size) begin
                pos_new = pos_cur - step_size;
            end else begin
                pos_new = (WRAP != 0) ? pos_cur + FIELD_W - step_size : 0;
            end
        end else if (dir == DIR_DEC) begin
            pos_new = pos_cur + step_size;
            if ((WRAP != 0) && (pos_new >= FIELD_W)) begin
                pos_new = pos_new - FIELD_W;
            end
        end
        // Step first, then clamp against the limit implied by the new length.
        if ((WRAP == 0) && (pos_new > lim)) begin
            pos_new = lim;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_q      <= POS_W'((FIELD_W - RESET_LEN) / 2);
            len_q      <= LENQ_W'(RESET_LEN);
            gap_q      <= GAP_W'(ACCEL_WINDOW);
            step_q     <= STEP_W'(1);
            last_dir_q <= DIR_NONE;
        end else begin
            len_q <= LENQ_W'(len_next);
            pos_q <= POS_W'(pos_new);
            if (dir != DIR_NONE) begin
                gap_q      <= '0;
                step_q     <= STEP_W'(step_size);
                last_dir_q <= dir;
            end else begin
                if (32'(gap_q) < ACCEL_WINDOW) begin
                    gap_q <= gap_q + GAP_W'(1);
                end
                if (illegal) begin
                    last_dir_q <= DIR_NONE;
                end
            end
        end
    end

    // In clamp mode pos+len never exceeds FIELD_W, so the modular form covers both modes.
    always_comb begin
        paddle_o = '0;
        for (int unsigned i = 0; i < FIELD_W; i++) begin
            if (i >= 32'(pos_q)) begin
                paddle_o[i] = (i - 32'(pos_q)) < 32'(len_q);
            end else begin
                paddle_o[i] = (i + FIELD_W - 32'(pos_q)) < 32'(len_q);
            end
        end
    end

    assign pos_o      = pos_q;
    assign at_edge_lo = (WRAP == 0) && (pos_q == '0);
    assign at_edge_hi = (WRAP == 0) && (32'(pos_q) == FIELD_W - 32'(len_q));
    assign illegal_o  = illegal;

endmodule
